nco_tick_scheduler: RTL and testbench



---
 rtl/nco_clk_pkg.sv | 15 +
 rtl/nco_interval_timer.sv | 28 ++
 rtl/nco_tick_scheduler.sv | 144 ++++++++++++++
 tb/tb_nco_tick_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nco_clk_pkg.sv
// nco_clk_pkg: shared types, default widths and divisor helper for the NCO tick scheduler
package nco_clk_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int NCO_CNT_WIDTH   = 16;
    localparam int NCO_BURST_WIDTH = 16;
    localparam int NCO_DEFAULT_DIV = 4;

    // A divisor of zero behaves as one so the timer always has a reachable terminal count
    function automatic logic [31:0] sat_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/nco_interval_timer.sv
// nco_interval_timer: interval counter that flags the last cycle of a D-cycle interval
module nco_interval_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    assign tc = count_q == div - CNT_WIDTH'(1);

    // Count up while enabled and wrap to zero on terminal count, so the value never exceeds div-1
    always_comb begin
        count_d = clear ? '0 : en ? (tc ? '0 : count_q + CNT_WIDTH'(1)) : count_q;
    end

    // Interval counter register
    always_ff @(posedge clk_in) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/nco_tick_scheduler.sv
// nco_tick_scheduler: run-time programmable tick/clk_out generator with bursts and tick-aligned reconfiguration
module nco_tick_scheduler import nco_clk_pkg::*; #(
    parameter int CNT_WIDTH   = nco_clk_pkg::NCO_CNT_WIDTH,
    parameter int BURST_WIDTH = nco_clk_pkg::NCO_BURST_WIDTH,
    parameter int DEFAULT_DIV = nco_clk_pkg::NCO_DEFAULT_DIV
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CNT_WIDTH-1:0]   cfg_div,
    input  logic [BURST_WIDTH-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   tick,
    output logic                   clk_out,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   active_div
);

    state_t                 state_q, state_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0] active_burst_q, active_burst_d;
    logic [BURST_WIDTH-1:0] pend_burst_q, pend_burst_d;
    logic [CNT_WIDTH-1:0]   active_div_q, active_div_d;
    logic [CNT_WIDTH-1:0]   pend_div_q, pend_div_d;
    logic                   tick_q, tick_d;
    logic                   clk_out_q, clk_out_d;
    logic                   done_q, done_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   pending_valid_q, pending_valid_d;
    logic [CNT_WIDTH-1:0]   div_sat;
    logic                   accept, running, timer_tc;
    logic                   apply_pend, to_active, to_pend;

    assign accept     = cfg_valid && cfg_ready_q;
    assign running    = state_q == RUN;
    assign div_sat    = CNT_WIDTH'(sat_div(32'(active_div_q)));
    assign cfg_ready  = cfg_ready_q;
    assign tick       = tick_q;
    assign clk_out    = clk_out_q;
    assign busy       = running;
    assign done       = done_q;
    assign active_div = active_div_q;

    nco_interval_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk_in (clk_in),
        .rst    (rst),
        .clear  (!running || stop),
        .en     (running),
        .div    (div_sat),
        .tc     (timer_tc)
    );

    // Scheduler next state; leaving RUN lands configs straight in the active slot so nothing is left pending in IDLE
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        active_div_d    = active_div_q;
        active_burst_d  = active_burst_q;
        pend_div_d      = pend_div_q;
        pend_burst_d    = pend_burst_q;
        pending_valid_d = pending_valid_q;
        clk_out_d       = clk_out_q;
        tick_d          = 1'b0;
        done_d          = 1'b0;
        apply_pend      = 1'b0;
        to_active       = 1'b0;
        to_pend         = 1'b0;
        if (!running) begin
            to_active = accept;
            if (start && !stop) begin
                state_d     = RUN;
                remaining_d = active_burst_q;
            end
        end else if (stop) begin
            state_d    = IDLE;
            clk_out_d  = 1'b0;
            apply_pend = pending_valid_q;
            to_active  = accept;
        end else if (timer_tc) begin
            tick_d      = 1'b1;
            clk_out_d   = !clk_out_q;
            apply_pend  = pending_valid_q;
            remaining_d = (remaining_q != '0) ? remaining_q - BURST_WIDTH'(1) : remaining_q;
            if (remaining_q == BURST_WIDTH'(1)) begin
                done_d    = 1'b1;
                clk_out_d = 1'b0;
                state_d   = IDLE;
                to_active = accept;
            end else begin
                to_pend = accept;
            end
        end else begin
            to_pend = accept;
        end
        if (apply_pend) begin
            active_div_d    = pend_div_q;
            active_burst_d  = pend_burst_q;
            pending_valid_d = 1'b0;
        end
        if (to_active) begin
            active_div_d   = cfg_div;
            active_burst_d = cfg_burst;
        end
        if (to_pend) begin
            pend_div_d      = cfg_div;
            pend_burst_d    = cfg_burst;
            pending_valid_d = 1'b1;
        end
        cfg_ready_d = !pending_valid_d;
    end

    // Scheduler state and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            active_div_q    <= CNT_WIDTH'(DEFAULT_DIV);
            active_burst_q  <= '0;
            pend_div_q      <= '0;
            pend_burst_q    <= '0;
            pending_valid_q <= 1'b0;
            cfg_ready_q     <= 1'b1;
            tick_q          <= 1'b0;
            clk_out_q       <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            active_div_q    <= active_div_d;
            active_burst_q  <= active_burst_d;
            pend_div_q      <= pend_div_d;
            pend_burst_q    <= pend_burst_d;
            pending_valid_q <= pending_valid_d;
            cfg_ready_q     <= cfg_ready_d;
            tick_q          <= tick_d;
            clk_out_q       <= clk_out_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_nco_tick_scheduler.sv
// tb_nco_tick_scheduler: directed and random stimulus checked against a countdown-based reference model
module tb_nco_tick_scheduler;

    localparam int CW = 16;
    localparam int BW = 16;

    logic          clk_in = 1'b0;
    logic          rst, cfg_valid, start, stop;
    logic [CW-1:0] cfg_div;
    logic [BW-1:0] cfg_burst;
    logic          cfg_ready, tick, clk_out, busy, done;
    logic [CW-1:0] active_div;

    int n_checks = 0;
    int n_fails  = 0;

    int m_run, m_left, m_rem, m_tick, m_clk, m_done, m_pend, m_pdiv, m_pburst, m_adiv, m_aburst, m_ready;

    nco_tick_scheduler dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .active_div (active_div)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int dof(input int a);
        return (a == 0) ? 1 : a;
    endfunction

    task automatic drive(input logic r, input logic v, input int d, input int b, input logic st, input logic sp);
        rst       = r;
        cfg_valid = v;
        cfg_div   = CW'(d);
        cfg_burst = BW'(b);
        start     = st;
        stop      = sp;
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare all outputs
    task automatic step();
        int acc;
        int old_ab;
        @(posedge clk_in);
        acc = (cfg_valid && m_ready != 0) ? 1 : 0;
        if (rst) begin
            m_run = 0; m_left = 0; m_rem = 0; m_tick = 0; m_clk = 0; m_done = 0;
            m_pend = 0; m_adiv = 4; m_aburst = 0;
        end else if (m_run == 0) begin
            m_tick = 0;
            m_done = 0;
            old_ab = m_aburst;
            if (acc != 0) begin m_adiv = int'(cfg_div); m_aburst = int'(cfg_burst); end
            if (start && !stop) begin m_run = 1; m_rem = old_ab; m_left = dof(m_adiv); end
        end else if (stop) begin
            m_run = 0; m_tick = 0; m_clk = 0; m_done = 0;
            if (m_pend != 0) begin m_adiv = m_pdiv; m_aburst = m_pburst; m_pend = 0; end
            if (acc != 0) begin m_adiv = int'(cfg_div); m_aburst = int'(cfg_burst); end
        end else begin
            m_done = 0;
            m_left--;
            if (m_left == 0) begin
                m_tick = 1;
                m_clk  = 1 - m_clk;
                if (m_pend != 0) begin m_adiv = m_pdiv; m_aburst = m_pburst; m_pend = 0; end
                if (m_rem != 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1; m_clk = 0; m_run = 0;
                        if (acc != 0) begin m_adiv = int'(cfg_div); m_aburst = int'(cfg_burst); acc = 0; end
                    end
                end
                if (acc != 0) begin m_pdiv = int'(cfg_div); m_pburst = int'(cfg_burst); m_pend = 1; end
                m_left = dof(m_adiv);
            end else begin
                m_tick = 0;
                if (acc != 0) begin m_pdiv = int'(cfg_div); m_pburst = int'(cfg_burst); m_pend = 1; end
            end
        end
        m_ready = (m_pend == 0) ? 1 : 0;
        #1;
        check("tick",       32'(tick),       32'(m_tick));
        check("clk_out",    32'(clk_out),    32'(m_clk));
        check("busy",       32'(busy),       32'(m_run));
        check("done",       32'(done),       32'(m_done));
        check("cfg_ready",  32'(cfg_ready),  32'(m_ready));
        check("active_div", 32'(active_div), 32'(m_adiv));
    endtask

    task automatic idle_steps(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        m_ready = 1;
        m_pend  = 0;
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) step();
        check("reset_active_div", 32'(active_div), 32'd4);
        check("reset_cfg_ready",  32'(cfg_ready),  32'd1);
        // Continuous run at D=4
        drive(0, 1, 4, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step();
        idle_steps(20);
        drive(0, 0, 0, 0, 0, 1); step();
        idle_steps(2);
        // Burst of 5 at D=3
        drive(0, 1, 3, 5, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step();
        idle_steps(20);
        // D=10 then retune to 2 mid-interval
        drive(0, 1, 10, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step();
        idle_steps(3);
        drive(0, 1, 2, 0, 0, 0); step();
        idle_steps(20);
        drive(0, 0, 0, 0, 0, 1); step();
        // Start and stop together in IDLE, then stop mid-run
        drive(0, 0, 0, 0, 1, 1); step();
        idle_steps(2);
        drive(0, 0, 0, 0, 1, 0); step();
        idle_steps(5);
        drive(0, 0, 0, 0, 0, 1); step();
        idle_steps(2);
        // Divisor 0 and 1 both tick every cycle
        for (int d = 0; d < 2; d++) begin
            drive(0, 1, d, 0, 0, 0); step();
            drive(0, 0, 0, 0, 1, 0); step();
            idle_steps(6);
            drive(0, 0, 0, 0, 0, 1); step();
        end
        // Reset mid-run with a pending config
        drive(0, 1, 7, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step();
        idle_steps(3);
        drive(0, 1, 3, 2, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); step();
        check("rst_pending_dropped", 32'(cfg_ready), 32'd1);
        check("rst_default_div",     32'(active_div), 32'd4);
        idle_steps(2);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                  ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
